// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Constants and types shared by the UART wrapper and its transmit-side feeder.
//   UART_DATA_W  : width of one UART data byte
//   tx_state_t   : pacing FSM states of the transmit feeder
//   BR_BAUD /
//   br_divisor() : baud-rate table indexed by BR_Select and the matching clock
//                  divisor for a 16x oversampling baud generator
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    DRAIN = 2'd2
  } tx_state_t;

  localparam int unsigned CLK_HZ     = 50_000_000;
  localparam int unsigned OVERSAMPLE = 16;

  // Baud rates selectable through the wrapper's 3-bit BR_Select input.
  localparam int unsigned BR_BAUD [8] = '{
    9600, 19200, 38400, 57600, 115200, 230400, 460800, 921600
  };

  function automatic int unsigned br_divisor(input logic [2:0] br_select);
    return CLK_HZ / (OVERSAMPLE * BR_BAUD[br_select]);
  endfunction

endpackage

// File: rtl/uart_tx_fifo_feeder_if.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo_feeder_if
// Bundles the host push side and the transmitter side of the feeder.
//   Host side   : Wr_En, Wr_Data (to feeder); Full, Empty, Count, Busy (from)
//   Transmitter : Tx_Ready (to feeder); Tx_Enable, Tx_Data (from feeder)
//   With UART_TX_FIFO_OVF_EN defined: Overflow (from), Ovf_Clr (to feeder)
// Modports: slave = the feeder, master = whoever drives it (host + transmitter).
// -----------------------------------------------------------------------------
interface uart_tx_fifo_feeder_if
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic                   Wr_En;
  logic [UART_DATA_W-1:0] Wr_Data;
  logic                   Full;
  logic                   Empty;
  logic [AW:0]            Count;
  logic                   Tx_Ready;
  logic                   Tx_Enable;
  logic [UART_DATA_W-1:0] Tx_Data;
  logic                   Busy;
`ifdef UART_TX_FIFO_OVF_EN
  logic                   Overflow;
  logic                   Ovf_Clr;
`endif

  modport slave (
    input  Wr_En, Wr_Data, Tx_Ready,
    output Full, Empty, Count, Tx_Enable, Tx_Data, Busy
`ifdef UART_TX_FIFO_OVF_EN
    , output Overflow
    , input  Ovf_Clr
`endif
  );

  modport master (
    output Wr_En, Wr_Data, Tx_Ready,
    input  Full, Empty, Count, Tx_Enable, Tx_Data, Busy
`ifdef UART_TX_FIFO_OVF_EN
    , input  Overflow
    , output Ovf_Clr
`endif
  );

endinterface

// File: rtl/uart_sync_fifo.sv
// -----------------------------------------------------------------------------
// uart_sync_fifo
// Single-clock FIFO: storage, wrapping pointers, occupancy count, Full/Empty.
//   clk, rst_n  : clock, asynchronous active-low reset
//   wr_en       : push request; ignored while full
//   wr_data     : byte to push
//   pop         : pop request; ignored while empty
//   rd_data     : head entry (valid while not empty)
//   full, empty : registered flags derived from the count
//   count       : registered occupancy, 0..DEPTH
//   empty_next  : empty flag the next edge will load (lets the owner register
//                 status that depends on it without a cycle of lag)
// -----------------------------------------------------------------------------
module uart_sync_fifo #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count,
  output logic             empty_next
);

  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]      count_reg, count_next;
  logic             full_reg, empty_reg;
  logic             push_ok, pop_ok;

  // Full is the registered flag, so a push while full is dropped even if a
  // pop frees a slot on the same edge.
  assign push_ok = wr_en && !full_reg;
  assign pop_ok  = pop && !empty_reg;

  always_comb begin
    count_next = count_reg;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count_reg + CNT_ONE;
      2'b01:   count_next = count_reg - CNT_ONE;
      default: count_next = count_reg;
    endcase
  end

  assign empty_next = (count_next == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      count_reg <= count_next;
      full_reg  <= (count_next == FULL_CNT);
      empty_reg <= empty_next;
    end
  end

  // Storage carries no reset; contents are meaningless once pointers clear.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= wr_data;
  end

  assign rd_data = mem[rd_ptr_reg];
  assign full    = full_reg;
  assign empty   = empty_reg;
  assign count   = count_reg;

endmodule

// File: rtl/uart_tx_fifo_feeder.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo_feeder
// Byte FIFO plus pacing FSM in front of the UART transmitter. The host pushes
// bytes at any rate; the FSM pops one byte at a time into Tx_Data, raises
// Tx_Enable until the transmitter drops Tx_Ready, then waits for Tx_Ready to
// return before the next byte. Tx_Data is stable for the whole frame.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : uart_tx_fifo_feeder_if.slave (Wr_En, Wr_Data, Full, Empty,
//                Count, Tx_Ready, Tx_Enable, Tx_Data, Busy)
// Optional: define UART_TX_FIFO_OVF_EN to add the sticky Overflow flag and its
// Ovf_Clr input to the interface.
// -----------------------------------------------------------------------------
module uart_tx_fifo_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  uart_tx_fifo_feeder_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  logic [UART_DATA_W-1:0] fifo_rd_data;
  logic                   fifo_full, fifo_empty, fifo_empty_next;
  logic [AW:0]            fifo_count;

  tx_state_t              state_reg, state_next;
  logic                   pop;
  logic                   tx_enable_reg, tx_enable_next;
  logic [UART_DATA_W-1:0] tx_data_reg;
  logic                   busy_reg, busy_next;

  uart_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (UART_DATA_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (bus.Wr_En),
    .wr_data    (bus.Wr_Data),
    .pop        (pop),
    .rd_data    (fifo_rd_data),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count),
    .empty_next (fifo_empty_next)
  );

  // Tx_Enable is registered from the ARM decision, so it rises one edge after
  // the pop and falls on the edge that samples Tx_Ready low.
  always_comb begin
    state_next     = state_reg;
    pop            = 1'b0;
    tx_enable_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty && bus.Tx_Ready) begin
          pop        = 1'b1;
          state_next = ARM;
        end
      end
      ARM: begin
        if (!bus.Tx_Ready) state_next = DRAIN;
        else               tx_enable_next = 1'b1;
      end
      DRAIN: begin
        if (bus.Tx_Ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    busy_next = (state_next != IDLE) || !fifo_empty_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      tx_enable_reg <= 1'b0;
      tx_data_reg   <= '0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      tx_enable_reg <= tx_enable_next;
      busy_reg      <= busy_next;
      if (pop) tx_data_reg <= fifo_rd_data;
    end
  end

`ifdef UART_TX_FIFO_OVF_EN
  logic ovf_reg;

  // Set has priority over clear so a coinciding drop is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          ovf_reg <= 1'b0;
    else if (bus.Wr_En && fifo_full)     ovf_reg <= 1'b1;
    else if (bus.Ovf_Clr)                ovf_reg <= 1'b0;
  end

  assign bus.Overflow = ovf_reg;
`endif

  assign bus.Full      = fifo_full;
  assign bus.Empty     = fifo_empty;
  assign bus.Count     = fifo_count;
  assign bus.Tx_Enable = tx_enable_reg;
  assign bus.Tx_Data   = tx_data_reg;
  assign bus.Busy      = busy_reg;

endmodule

// File: tb/tb_uart_tx_fifo_feeder.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo_feeder
// Directed bench for uart_tx_fifo_feeder (DEPTH = 16). A simple transmitter
// model is driven by hand: Tx_Ready drops after Tx_Enable is seen and returns
// a few cycles later. Overflow checks run when UART_TX_FIFO_OVF_EN is defined.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo_feeder;

  logic clk;
  logic rst_n;
  int   checks;
  int   passes;
  int   fails;

  uart_tx_fifo_feeder_if #(.DEPTH(16)) bus ();

  uart_tx_fifo_feeder #(.DEPTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    bus.Wr_En   = 1'b1;
    bus.Wr_Data = d;
    step();
    bus.Wr_En   = 1'b0;
  endtask

  // Transmitter model for one frame: wait (bounded) for Tx_Enable, check the
  // byte, drop Tx_Ready, hold it low for a few cycles, then release it.
  task automatic serve(input logic [7:0] exp);
    int n = 0;
    while (bus.Tx_Enable !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    chk("serve_enable", {31'd0, bus.Tx_Enable}, 32'd1);
    chk("serve_data", {24'd0, bus.Tx_Data}, {24'd0, exp});
    bus.Tx_Ready = 1'b0;
    step();
    chk("serve_enable_drop", {31'd0, bus.Tx_Enable}, 32'd0);
    repeat (3) step();
    chk("serve_data_stable", {24'd0, bus.Tx_Data}, {24'd0, exp});
    bus.Tx_Ready = 1'b1;
    step();
  endtask

  initial begin
    checks = 0;
    passes = 0;
    fails  = 0;
    rst_n        = 1'b0;
    bus.Wr_En    = 1'b0;
    bus.Wr_Data  = 8'h00;
    bus.Tx_Ready = 1'b1;
`ifdef UART_TX_FIFO_OVF_EN
    bus.Ovf_Clr  = 1'b0;
`endif

    // ---- reset state
    repeat (3) step();
    chk("rst_count", {27'd0, bus.Count}, 32'd0);
    chk("rst_empty", {31'd0, bus.Empty}, 32'd1);
    chk("rst_full", {31'd0, bus.Full}, 32'd0);
    chk("rst_tx_enable", {31'd0, bus.Tx_Enable}, 32'd0);
    chk("rst_tx_data", {24'd0, bus.Tx_Data}, 32'd0);
    chk("rst_busy", {31'd0, bus.Busy}, 32'd0);
`ifdef UART_TX_FIFO_OVF_EN
    chk("rst_overflow", {31'd0, bus.Overflow}, 32'd0);
`endif
    rst_n = 1'b1;
    step();

    // ---- single byte: pop one edge after the push, enable one edge later
    push(8'hA5);
    chk("single_count_after_push", {27'd0, bus.Count}, 32'd1);
    chk("single_busy", {31'd0, bus.Busy}, 32'd1);
    step();
    chk("single_enable_edge1", {31'd0, bus.Tx_Enable}, 32'd0);
    chk("single_data_popped", {24'd0, bus.Tx_Data}, 32'hA5);
    chk("single_count_after_pop", {27'd0, bus.Count}, 32'd0);
    step();
    chk("single_enable_edge2", {31'd0, bus.Tx_Enable}, 32'd1);
    bus.Tx_Ready = 1'b0;
    step();
    chk("single_enable_after_drop", {31'd0, bus.Tx_Enable}, 32'd0);
    chk("single_busy_drain", {31'd0, bus.Busy}, 32'd1);
    repeat (9) step();
    chk("single_drain_enable", {31'd0, bus.Tx_Enable}, 32'd0);
    chk("single_drain_data", {24'd0, bus.Tx_Data}, 32'hA5);
    bus.Tx_Ready = 1'b1;
    step();
    chk("single_idle_busy", {31'd0, bus.Busy}, 32'd0);
    chk("single_idle_empty", {31'd0, bus.Empty}, 32'd1);

    // ---- burst to full with the transmitter busy; 17th push dropped
    bus.Tx_Ready = 1'b0;
    for (int i = 0; i < 16; i++) push(8'(i));
    chk("burst_full", {31'd0, bus.Full}, 32'd1);
    chk("burst_count", {27'd0, bus.Count}, 32'd16);
    chk("burst_no_enable", {31'd0, bus.Tx_Enable}, 32'd0);
    push(8'hFF);
    chk("burst_drop_count", {27'd0, bus.Count}, 32'd16);
`ifdef UART_TX_FIFO_OVF_EN
    chk("ovf_set", {31'd0, bus.Overflow}, 32'd1);
    bus.Ovf_Clr = 1'b1;
    step();
    chk("ovf_clear", {31'd0, bus.Overflow}, 32'd0);
    bus.Wr_En   = 1'b1;
    bus.Wr_Data = 8'hFF;
    step();
    bus.Wr_En   = 1'b0;
    bus.Ovf_Clr = 1'b0;
    chk("ovf_set_wins", {31'd0, bus.Overflow}, 32'd1);
    chk("ovf_drop_count", {27'd0, bus.Count}, 32'd16);
`endif
    bus.Tx_Ready = 1'b1;
    for (int i = 0; i < 16; i++) serve(8'(i));
    repeat (20) step();
    chk("burst_no_ff_enable", {31'd0, bus.Tx_Enable}, 32'd0);
    chk("burst_drained_empty", {31'd0, bus.Empty}, 32'd1);
    chk("burst_last_data", {24'd0, bus.Tx_Data}, 32'h0F);

    // ---- simultaneous push and pop keeps Count
    bus.Tx_Ready = 1'b0;
    for (int i = 0; i < 5; i++) push(8'(8'h10 + i));
    chk("sim_count5", {27'd0, bus.Count}, 32'd5);
    bus.Tx_Ready = 1'b1;
    push(8'h15);
    chk("sim_count_same", {27'd0, bus.Count}, 32'd5);
    chk("sim_popped_head", {24'd0, bus.Tx_Data}, 32'h10);
    for (int i = 0; i < 6; i++) serve(8'(8'h10 + i));

    // ---- transmitter not ready in IDLE: no pop for 100 cycles
    bus.Tx_Ready = 1'b0;
    for (int i = 0; i < 3; i++) push(8'(8'h16 + i));
    repeat (100) step();
    chk("hold_count", {27'd0, bus.Count}, 32'd3);
    chk("hold_enable", {31'd0, bus.Tx_Enable}, 32'd0);
    chk("hold_busy", {31'd0, bus.Busy}, 32'd1);
    chk("hold_data", {24'd0, bus.Tx_Data}, 32'h15);
    bus.Tx_Ready = 1'b1;
    for (int i = 0; i < 3; i++) serve(8'(8'h16 + i));

    // ---- more bytes so the pointers wrap again (40 accepted in total)
    bus.Tx_Ready = 1'b0;
    for (int i = 0; i < 14; i++) push(8'(8'h19 + i));
    chk("wrap_count", {27'd0, bus.Count}, 32'd14);
    bus.Tx_Ready = 1'b1;
    for (int i = 0; i < 14; i++) serve(8'(8'h19 + i));
    chk("wrap_empty", {31'd0, bus.Empty}, 32'd1);

    // ---- reset mid-frame
    push(8'h30);
    push(8'h31);
    begin
      int n = 0;
      while (bus.Tx_Enable !== 1'b1 && n < 20) begin
        step();
        n++;
      end
    end
    chk("midrst_enable_before", {31'd0, bus.Tx_Enable}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_enable_async", {31'd0, bus.Tx_Enable}, 32'd0);
    repeat (3) step();
    chk("midrst_count", {27'd0, bus.Count}, 32'd0);
    chk("midrst_empty", {31'd0, bus.Empty}, 32'd1);
    chk("midrst_tx_data", {24'd0, bus.Tx_Data}, 32'd0);
    chk("midrst_busy", {31'd0, bus.Busy}, 32'd0);
    rst_n = 1'b1;
    repeat (5) step();
    chk("midrst_after_enable", {31'd0, bus.Tx_Enable}, 32'd0);
    chk("midrst_after_empty", {31'd0, bus.Empty}, 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo_feeder.md
Name: uart_tx_fifo_feeder

Overview:
- Byte FIFO plus a pacing FSM placed directly upstream of the variable-baud UART wrapper's transmit path.
- Accepts bytes from the host side at any rate.
- Presents one byte at a time on Tx_Data and handshakes Enable against the transmitter's Tx_Ready, so the host never has to watch transmitter timing.
- Works at any selected baud; the byte held on Tx_Data stays stable for the whole frame.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- AW, $clog2(DEPTH), pointer width (derived, not overridden).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- Wr_En  in  1  push request, one byte per cycle
- Wr_Data  in  8  byte to push
- Full  out  1  FIFO holds DEPTH entries
- Empty  out  1  FIFO holds 0 entries
- Count  out  AW+1  current occupancy, 0..DEPTH
- Tx_Ready  in  1  transmitter idle, from the transmitter
- Tx_Enable  out  1  to the transmitter's Enable input
- Tx_Data  out  8  to the transmitter's Tx_Data/Tx_Parallel input
- Busy  out  1  FSM not in IDLE, or FIFO not empty

Behaviour:
- Reset (async assert, sync-released by the integrator) sets:
  - pointers = 0, Count = 0, Empty = 1, Full = 0;
  - Tx_Enable = 0, Tx_Data = 8'h00, Busy = 0;
  - state = IDLE.
- All outputs are registered.
- Push: accepted iff Wr_En=1 and Full=0 at that edge. Full is evaluated before any same-cycle pop, so a push while Full is dropped even if a pop happens in the same cycle.
- Pop: performed only by the FSM, never when Empty=1.
- Push and pop in the same cycle leave Count unchanged.
- Pointers wrap modulo DEPTH. Full and Empty are derived from Count.
- FSM states:
  - IDLE: if Empty=0 and Tx_Ready=1, pop the head into Tx_Data and go to ARM.
  - ARM: Tx_Enable=1. Stay until Tx_Ready=0 is sampled, then go to DRAIN with Tx_Enable=0 on the next cycle.
  - DRAIN: Tx_Enable=0. Stay until Tx_Ready=1, then go to IDLE.
- Tx_Data holds the popped byte from the pop edge until the next pop; it does not change during ARM or DRAIN.
- Latency: a push into an empty FIFO while idle gives Tx_Enable=1 on the second clock edge after the push edge.
- Back-to-back bytes cost 1 IDLE cycle between Tx_Ready rising and the next Tx_Enable.
- Tx_Ready=0 while in IDLE (baud change or transmitter busy): no pop; wait.
- Reset mid-frame: FIFO contents discarded, Tx_Enable drops immediately. The transmitter's in-flight frame is not this block's concern.
- Count never exceeds DEPTH and never underflows.

Optional Feature:
- Macro: UART_TX_FIFO_OVF_EN.
- With the macro defined:
  - adds port Overflow  out  1: sticky, set on the edge of any push attempt while Full=1;
  - adds port Ovf_Clr  in  1: clears Overflow. If set and clear coincide, set wins;
  - Overflow resets to 0.
- Without the macro: both ports are absent and dropped pushes are silent.

Decomposition:
- Shared package uart_pkg holds:
  - UART_DATA_W = 8;
  - the FSM state enum (IDLE, ARM, DRAIN);
  - the BR_Select baud-divisor constant table, so it is shared with the wrapper.
- One natural sub-module, uart_sync_fifo: storage, pointers, Count, Full/Empty.
- The FSM and the Tx_Data register stay in the top.

Test Plan:
- Reset: hold rst_n=0 mid-operation for 3 cycles -> Count=0, Empty=1, Tx_Enable=0, Tx_Data=8'h00, state IDLE.
- Single byte: push 8'hA5 with Tx_Ready=1 -> Tx_Enable=1 two edges later with Tx_Data=8'hA5. Model drops Tx_Ready for 10 cycles -> Tx_Enable=0 the cycle after the drop; back to IDLE after Tx_Ready rises; Empty=1.
- Burst of 16 bytes 8'h00..8'h0F with Tx_Ready=0 -> Full=1, Count=16. A 17th push (8'hFF) is dropped. Releasing the transmitter model gives bytes out in order 00..0F, never FF.
- Simultaneous push/pop: Count=5, push while the FSM pops -> Count stays 5; order is preserved across pointer wrap after 40 total bytes.
- Tx_Ready held low in IDLE with Count=3 for 100 cycles -> no pop, Tx_Enable=0, Count=3, Busy=1.
- UART_TX_FIFO_OVF_EN defined: push while Full -> Overflow=1 next edge. Ovf_Clr pulse -> Overflow=0. Push-while-Full and Ovf_Clr in the same cycle -> Overflow stays 1.
